// File: rtl/sm4_host_ctrl.sv
// Host-side initiator for the SM4 core: gathers 32-bit words into key/data blocks,
// sequences the core's control inputs and streams 128-bit results back as 32-bit words.
module sm4_host_ctrl #(
  parameter int TIMEOUT = 128,
  parameter int CNT_W   = 8
) (
  input  logic         top_clk,
  input  logic         top_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_word,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_word,
  output logic         out_last,
  output logic [1:0]   core_opcode,
  output logic [127:0] core_key,
  output logic [127:0] core_datain,
  output logic         core_handshake,
  output logic         core_last,
  input  logic         core_rk_complete,
  input  logic         core_data_complete,
  input  logic [127:0] core_dataout,
  output logic         key_loaded,
  output logic         err
);

  localparam logic [1:0]       OP_KEY  = 2'b00;
  localparam logic [1:0]       OP_PARK = 2'b10;
  localparam logic [CNT_W-1:0] T_MAX   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] T_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    GATHER,
    KEY_RUN,
    KEY_ACK,
    DATA_RUN,
    DRAIN
  } state_t;

  state_t             state, state_next;
  logic [95:0]        asm_q;
  logic [1:0]         word_cnt;
  logic [1:0]         op_q;
  logic [CNT_W-1:0]   tcnt;
  logic [1:0]         idx;
  logic [127:0]       result_q;

  logic               in_fire;
  logic               out_fire;
  logic               tcnt_last;
  logic [127:0]       block;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign tcnt_last = (tcnt == T_LAST);
  assign block     = {asm_q, in_word};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (in_fire) state_next = GATHER;
      GATHER: begin
        if (in_fire && (word_cnt == 2'd3)) begin
          if (op_q == OP_KEY)              state_next = KEY_RUN;
          else if (op_q[0] && key_loaded)  state_next = DATA_RUN;
          else                             state_next = IDLE;
        end
      end
      KEY_RUN: begin
        if (core_rk_complete) state_next = KEY_ACK;
        else if (tcnt_last)   state_next = IDLE;
      end
      KEY_ACK:  state_next = IDLE;
      DATA_RUN: begin
        if (core_data_complete) state_next = DRAIN;
        else if (tcnt_last)     state_next = IDLE;
      end
      DRAIN:    if (out_fire && (idx == 2'd3)) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Every output is registered; the opcode parks at 10 whenever the core is not busy
  // so its data path is cleared before the next block is applied.
  always_ff @(posedge top_clk) begin
    if (top_rst) begin
      state          <= IDLE;
      in_ready       <= 1'b0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      out_word       <= '0;
      core_opcode    <= OP_PARK;
      core_key       <= '0;
      core_datain    <= '0;
      core_handshake <= 1'b0;
      core_last      <= 1'b0;
      key_loaded     <= 1'b0;
      err            <= 1'b0;
      word_cnt       <= '0;
      tcnt           <= '0;
      idx            <= '0;
      op_q           <= '0;
      asm_q          <= '0;
      result_q       <= '0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == IDLE) || (state_next == GATHER);
      case (state)
        IDLE: begin
          if (in_fire) begin
            op_q     <= in_op;
            asm_q    <= {asm_q[63:0], in_word};
            word_cnt <= 2'd1;
          end
        end
        GATHER: begin
          if (in_fire) begin
            asm_q    <= {asm_q[63:0], in_word};
            word_cnt <= word_cnt + 2'd1;
            if (word_cnt == 2'd3) begin
              case (state_next)
                KEY_RUN: begin
                  core_key       <= block;
                  core_opcode    <= OP_KEY;
                  core_handshake <= 1'b1;
                  key_loaded     <= 1'b0;
                  tcnt           <= '0;
                end
                DATA_RUN: begin
                  core_datain <= block;
                  core_opcode <= op_q;
                  tcnt        <= '0;
                end
                default: err <= 1'b1;
              endcase
            end
          end
        end
        KEY_RUN: begin
          if (core_rk_complete) begin
            core_last      <= 1'b1;
            core_handshake <= 1'b0;
            core_opcode    <= OP_PARK;
            key_loaded     <= 1'b1;
          end else begin
            if (tcnt != T_MAX) tcnt <= tcnt + 1'b1;
            if (tcnt_last) begin
              err            <= 1'b1;
              core_opcode    <= OP_PARK;
              core_handshake <= 1'b0;
            end
          end
        end
        KEY_ACK: core_last <= 1'b0;
        DATA_RUN: begin
          if (core_data_complete) begin
            result_q    <= core_dataout;
            core_opcode <= OP_PARK;
            idx         <= 2'd0;
            out_valid   <= 1'b1;
            out_last    <= 1'b0;
            out_word    <= core_dataout[127:96];
          end else begin
            if (tcnt != T_MAX) tcnt <= tcnt + 1'b1;
            if (tcnt_last) begin
              err            <= 1'b1;
              core_opcode    <= OP_PARK;
              core_handshake <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (idx == 2'd3) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              idx      <= idx + 2'd1;
              result_q <= {result_q[95:0], 32'h0};
              out_word <= result_q[95:64];
              out_last <= (idx == 2'd2);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_host_ctrl.sv
// Directed bench for sm4_host_ctrl: key load, encrypt with and without backpressure,
// missing key, timeout and mid-operation resets, with a hand-driven core model.
module tb_sm4_host_ctrl;

  localparam int          TB_TIMEOUT = 128;
  localparam logic [127:0] KEY_BLK   = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] CT_BLK    = 128'h681EDF34D206965E86B3E94F536E4246;

  logic         top_clk = 1'b0;
  logic         top_rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_word = '0;
  logic [1:0]   in_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_word;
  logic         out_last;
  logic [1:0]   core_opcode;
  logic [127:0] core_key;
  logic [127:0] core_datain;
  logic         core_handshake;
  logic         core_last;
  logic         core_rk_complete = 1'b0;
  logic         core_data_complete = 1'b0;
  logic [127:0] core_dataout = '0;
  logic         key_loaded;
  logic         err;

  int n_assert = 0;
  int n_fail   = 0;

  sm4_host_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(8)) dut (
    .top_clk            (top_clk),
    .top_rst            (top_rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_word            (in_word),
    .in_op              (in_op),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_word           (out_word),
    .out_last           (out_last),
    .core_opcode        (core_opcode),
    .core_key           (core_key),
    .core_datain        (core_datain),
    .core_handshake     (core_handshake),
    .core_last          (core_last),
    .core_rk_complete   (core_rk_complete),
    .core_data_complete (core_data_complete),
    .core_dataout       (core_dataout),
    .key_loaded         (key_loaded),
    .err                (err)
  );

  always #5 top_clk = ~top_clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_in_ready"},   in_ready,       1'b0);
    check_output({tag, "_out_valid"},  out_valid,      1'b0);
    check_output({tag, "_out_last"},   out_last,       1'b0);
    check_output({tag, "_out_word"},   out_word,       32'h0);
    check_output({tag, "_opcode"},     core_opcode,    2'b10);
    check_output({tag, "_core_key"},   core_key,       128'h0);
    check_output({tag, "_datain"},     core_datain,    128'h0);
    check_output({tag, "_handshake"},  core_handshake, 1'b0);
    check_output({tag, "_core_last"},  core_last,      1'b0);
    check_output({tag, "_key_loaded"}, key_loaded,     1'b0);
    check_output({tag, "_err"},        err,            1'b0);
  endtask

  task automatic do_reset();
    top_rst            = 1'b1;
    in_valid           = 1'b0;
    out_ready          = 1'b0;
    core_rk_complete   = 1'b0;
    core_data_complete = 1'b0;
    @(negedge top_clk);
    @(negedge top_clk);
    top_rst = 1'b0;
    check_reset_values("reset");
  endtask

  // Sends one block; words 1-3 carry the reserved op to prove it is ignored.
  task automatic apply_stimulus(input logic [127:0] blk, input logic [1:0] op);
    logic [127:0] b;
    b = blk;
    for (int w = 0; w < 4; w++) begin
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_word  = b[127 - 32*w -: 32];
      in_op    = (w == 0) ? op : 2'b10;
      while (!in_ready && guard < 50) begin
        @(negedge top_clk);
        guard++;
      end
      check_output("in_ready_wait", in_ready, 1'b1);
      @(negedge top_clk);
    end
    in_valid = 1'b0;
    in_word  = '0;
    in_op    = '0;
  endtask

  task automatic run_key_load();
    logic held;
    apply_stimulus(KEY_BLK, 2'b00);
    check_output("key_core_key",   core_key,       KEY_BLK);
    check_output("key_opcode",     core_opcode,    2'b00);
    check_output("key_handshake",  core_handshake, 1'b1);
    check_output("key_cleared",    key_loaded,     1'b0);
    check_output("key_in_ready",   in_ready,       1'b0);
    held = 1'b1;
    repeat (39) begin
      @(negedge top_clk);
      if (core_opcode !== 2'b00 || core_handshake !== 1'b1 || core_last !== 1'b0) held = 1'b0;
    end
    check_output("key_hold", held, 1'b1);
    core_rk_complete = 1'b1;
    @(negedge top_clk);
    core_rk_complete = 1'b0;
    check_output("ack_core_last", core_last,      1'b1);
    check_output("ack_handshake", core_handshake, 1'b0);
    check_output("ack_opcode",    core_opcode,    2'b10);
    @(negedge top_clk);
    check_output("post_ack_last",       core_last,   1'b0);
    check_output("post_ack_key_loaded", key_loaded,  1'b1);
    check_output("post_ack_opcode",     core_opcode, 2'b10);
    check_output("post_ack_in_ready",   in_ready,    1'b1);
    check_output("post_ack_core_key",   core_key,    KEY_BLK);
  endtask

  task automatic start_encrypt();
    apply_stimulus(KEY_BLK, 2'b01);
    check_output("enc_opcode",    core_opcode, 2'b01);
    check_output("enc_datain",    core_datain, KEY_BLK);
    check_output("enc_in_ready",  in_ready,    1'b0);
    check_output("enc_out_valid", out_valid,   1'b0);
    repeat (32) @(negedge top_clk);
    core_dataout       = CT_BLK;
    core_data_complete = 1'b1;
    @(negedge top_clk);
    core_data_complete = 1'b0;
    core_dataout       = '0;
    check_output("done_opcode",    core_opcode, 2'b10);
    check_output("done_out_valid", out_valid,   1'b1);
  endtask

  task automatic drain_result(input bit toggle);
    logic [127:0] ct;
    int idx;
    int c;
    ct  = CT_BLK;
    idx = 0;
    c   = 0;
    while (idx < 4 && c < 64) begin
      out_ready = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      check_output("drain_valid",    out_valid, 1'b1);
      check_output("drain_word",     out_word,  ct[127 - 32*idx -: 32]);
      check_output("drain_last",     out_last,  idx == 3);
      check_output("drain_in_ready", in_ready,  1'b0);
      if (out_ready) idx++;
      c++;
      @(negedge top_clk);
    end
    out_ready = 1'b0;
    check_output("drain_count",     idx,       4);
    check_output("drain_end_valid", out_valid, 1'b0);
    check_output("drain_end_last",  out_last,  1'b0);
    check_output("drain_end_ready", in_ready,  1'b1);
  endtask

  initial begin
    logic quiet;

    $display("[TB] reset and key load");
    @(negedge top_clk);
    do_reset();
    run_key_load();

    $display("[TB] encrypt with continuous ready");
    start_encrypt();
    drain_result(1'b0);

    $display("[TB] encrypt with stalled ready");
    start_encrypt();
    drain_result(1'b1);
    check_output("key_retained", key_loaded, 1'b1);

    $display("[TB] reset during gather");
    while (!in_ready) @(negedge top_clk);
    in_valid = 1'b1;
    in_word  = 32'h01234567;
    in_op    = 2'b00;
    @(negedge top_clk);
    in_word  = 32'h89ABCDEF;
    top_rst  = 1'b1;
    @(negedge top_clk);
    top_rst  = 1'b0;
    in_valid = 1'b0;
    check_reset_values("gather_rst");
    run_key_load();

    $display("[TB] reset during drain");
    start_encrypt();
    out_ready = 1'b1;
    @(negedge top_clk);
    check_output("partial_word1", out_word, 32'hD206965E);
    out_ready = 1'b0;
    top_rst   = 1'b1;
    @(negedge top_clk);
    top_rst   = 1'b0;
    check_reset_values("drain_rst");
    run_key_load();
    start_encrypt();
    drain_result(1'b0);

    $display("[TB] decrypt without key");
    do_reset();
    apply_stimulus(KEY_BLK, 2'b11);
    check_output("nokey_err",      err,         1'b1);
    check_output("nokey_opcode",   core_opcode, 2'b10);
    check_output("nokey_in_ready", in_ready,    1'b1);
    quiet = 1'b1;
    repeat (5) begin
      @(negedge top_clk);
      if (out_valid !== 1'b0 || core_opcode !== 2'b10) quiet = 1'b0;
    end
    check_output("nokey_quiet", quiet, 1'b1);
    run_key_load();
    check_output("err_sticky", err, 1'b1);

    $display("[TB] data timeout");
    do_reset();
    run_key_load();
    apply_stimulus(KEY_BLK, 2'b01);
    check_output("to_entry_opcode", core_opcode, 2'b01);
    repeat (TB_TIMEOUT - 1) @(negedge top_clk);
    check_output("to_before_err",    err,         1'b0);
    check_output("to_before_opcode", core_opcode, 2'b01);
    @(negedge top_clk);
    check_output("to_err",       err,         1'b1);
    check_output("to_opcode",    core_opcode, 2'b10);
    check_output("to_in_ready",  in_ready,    1'b1);
    check_output("to_out_valid", out_valid,   1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
